// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory shared between instruction fetch and load/store
//
// Purpose: arbitrates the CPU fetch port and data port onto one single-port memory with
// one access in flight at a time. Data has priority, but a streak limit bounds how many
// consecutive data grants may pass a waiting fetch.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   if_req/if_addr                   fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata        fetch accept pulse, data-valid pulse, read data
//   d_req/d_we/d_addr/d_wdata/d_wstrb data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata           data accept pulse, completion pulse, load data (0 for stores)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb  memory access strobe and command
//   mem_rdata                        memory read data, valid MEM_LATENCY cycles after mem_en
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STK_W  = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(MAX_DATA_STREAK);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t           state, state_n;
    owner_t           owner, owner_n;
    logic             owner_we, owner_we_n;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
    logic [STK_W-1:0] streak, streak_n;
    logic             data_wins;

    // Data wins unless fetch is also waiting and the data streak is exhausted.
    assign data_wins = d_req && (!if_req || (streak < STREAK_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= OWN_FETCH;
            owner_we <= 1'b0;
            lat_cnt  <= '0;
            streak   <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            owner_we <= owner_we_n;
            lat_cnt  <= lat_cnt_n;
            streak   <= streak_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        owner_we_n = owner_we;
        lat_cnt_n  = lat_cnt;
        streak_n   = streak;
        if_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        d_gnt      = 1'b0;
        d_rvalid   = 1'b0;
        d_rdata    = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;

        // Outputs are gated by reset so nothing leaks out while reset is held,
        // including a read completion that would otherwise land during reset.
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (data_wins) begin
                        d_gnt      = 1'b1;
                        mem_en     = 1'b1;
                        mem_we     = d_we;
                        mem_addr   = d_addr;
                        mem_wdata  = d_wdata;
                        mem_wstrb  = d_wstrb;
                        owner_n    = OWN_DATA;
                        owner_we_n = d_we;
                        lat_cnt_n  = LAT_INIT;
                        state_n    = S_WAIT;
                        // Only a grant that actually passed a waiting fetch counts.
                        streak_n   = if_req ? streak + STK_W'(1) : '0;
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = if_addr;
                        owner_n    = OWN_FETCH;
                        owner_we_n = 1'b0;
                        lat_cnt_n  = LAT_INIT;
                        state_n    = S_WAIT;
                        streak_n   = '0;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner == OWN_DATA) begin
                            d_rvalid = 1'b1;
                            d_rdata  = owner_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                        state_n = S_IDLE;
                    end else begin
                        lat_cnt_n = lat_cnt - LAT_W'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    logic unused_strb;
    assign unused_strb = (STRB_W == 0);
endmodule
